// File: rtl/cnn_layer_accel_pfb_rd_sequencer.sv
// Read-side sequencer for the per-row prefetch buffer: walks the padded/upsampled image row by row.
// Optional sticky protocol checking on seq_err is enabled by defining PFB_RD_SEQ_PROTOCOL_CHECK_EN.
`ifndef MAX_NUM_INPUT_COLS
`define MAX_NUM_INPUT_COLS 1024
`endif

module cnn_layer_accel_pfb_rd_sequencer #(
  parameter int C_COL_WIDTH = $clog2(`MAX_NUM_INPUT_COLS),
  parameter int C_PRIM_ROWS = 2
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  input  logic                   job_start,
  input  logic [C_COL_WIDTH-1:0] num_rows,
  input  logic [C_COL_WIDTH-1:0] num_cols,
  input  logic                   ce_ready,
  input  logic                   ce_idle,
  output logic                   fetch_req,
  input  logic                   job_fetch_ack,
  input  logic                   cncl_fetch_req,
  output logic                   job_complete_req,
  input  logic                   job_complete_ack,
  output logic                   pfb_rd_en,
  output logic                   pix_valid,
  output logic [C_COL_WIDTH-1:0] input_row,
  output logic [C_COL_WIDTH-1:0] input_col,
  output logic                   next_row,
  output logic                   rst_addr,
  output logic [5:0]             state,
  output logic                   seq_err
);

  typedef enum logic [5:0] {
    ST_IDLE               = 6'b000001,
    ST_AWE_CE_PRIM_BUFFER = 6'b000010,
    ST_WAIT_PFB_LOAD      = 6'b000100,
    ST_AWE_CE_ACTIVE      = 6'b001000,
    ST_WAIT_JOB_DONE      = 6'b010000,
    ST_SEND_COMPLETE      = 6'b100000
  } state_t;

  localparam logic [C_COL_WIDTH-1:0] PRIM_ROWS_W = C_COL_WIDTH'(C_PRIM_ROWS);
  localparam logic [C_COL_WIDTH-1:0] ONE_W       = C_COL_WIDTH'(1);

  state_t                 state_q;
  state_t                 state_d;
  logic [C_COL_WIDTH-1:0] row_q;
  logic [C_COL_WIDTH-1:0] col_q;
  logic [C_COL_WIDTH-1:0] nrows_q;
  logic [C_COL_WIDTH-1:0] ncols_q;
  logic [C_COL_WIDTH-1:0] row_inc;
  logic                   req_out_q;
  logic                   vld_p1;
  logic                   job_go;

  assign row_inc = row_q + ONE_W;
  assign job_go  = (state_q == ST_IDLE) && job_start;

  always_comb begin
    state_d          = state_q;
    fetch_req        = 1'b0;
    job_complete_req = 1'b0;
    pfb_rd_en        = 1'b0;
    next_row         = 1'b0;
    rst_addr         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          state_d = ((num_rows == '0) || (num_cols == '0)) ? ST_SEND_COMPLETE : ST_WAIT_PFB_LOAD;
        end
      end
      ST_WAIT_PFB_LOAD: begin
        // Once raised, the request is held through a late cancel until it is acked.
        fetch_req = req_out_q || !cncl_fetch_req;
        if (job_fetch_ack || (cncl_fetch_req && !req_out_q)) begin
          state_d = (row_q < PRIM_ROWS_W) ? ST_AWE_CE_PRIM_BUFFER : ST_AWE_CE_ACTIVE;
        end
      end
      ST_AWE_CE_PRIM_BUFFER, ST_AWE_CE_ACTIVE: begin
        if (col_q == ncols_q) begin
          next_row = 1'b1;
          rst_addr = 1'b1;
          state_d  = (row_inc == nrows_q) ? ST_WAIT_JOB_DONE : ST_WAIT_PFB_LOAD;
        end else begin
          pfb_rd_en = ce_ready;
        end
      end
      ST_WAIT_JOB_DONE: begin
        if (ce_idle && !vld_p1) begin
          state_d = ST_SEND_COMPLETE;
        end
      end
      ST_SEND_COMPLETE: begin
        job_complete_req = 1'b1;
        if (job_complete_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      req_out_q <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_out_q <= fetch_req && !job_fetch_ack;
      vld_p1    <= pfb_rd_en;
      if (job_go || ((state_q == ST_SEND_COMPLETE) && job_complete_ack)) begin
        row_q <= '0;
        col_q <= '0;
      end else if (pfb_rd_en) begin
        col_q <= col_q + ONE_W;
      end else if (next_row) begin
        col_q <= '0;
        row_q <= row_inc;
      end
    end
  end

  // Job geometry is data only; it is captured at job start and needs no reset.
  always_ff @(posedge rd_clk) begin
    if (job_go) begin
      nrows_q <= num_rows;
      ncols_q <= num_cols;
    end
  end

`ifdef PFB_RD_SEQ_PROTOCOL_CHECK_EN
  logic seq_err_q;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      seq_err_q <= 1'b0;
    end else if ((job_fetch_ack && (state_q != ST_WAIT_PFB_LOAD)) ||
                 (job_complete_ack && (state_q != ST_SEND_COMPLETE)) ||
                 (job_start && (state_q != ST_IDLE))) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  assign pix_valid = vld_p1;
  assign input_row = row_q;
  assign input_col = col_q;
  assign state     = state_q;

endmodule
